top_encoder: RTL and testbench
==============================

Name: top_encoder

Overview:
- Upstream (status) counterpart of the host command decoder: tracks the read and write DMA channels from command load through completion and encodes their state into the AXI-Lite readable register bank (reg_up).
- Sits beside the command decoder in the sample system. Consumes the decoded start/restart/valid/len strobes plus engine beat/done/error pulses. Produces reg_up and a level interrupt.

Parameters:
- AXIL_DATA_WIDTH, 64, register width; only 64 is supported.
- NUM_REGISTER, 4, number of registers in reg_up; must be >= 4, registers 4 and up read as zero.
- TOP_LEN_WIDTH, 20, transfer length and beat counter width; must be <= 24.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- read_valid  in  1  AXI-Lite register read strobe.
- access_addr  in  $clog2(NUM_REGISTER)  register index of the current access.
- read_start, read_restart, top_read_valid  in  1 each  decoded read-channel strobes.
- top_read_len  in  TOP_LEN_WIDTH  read length, qualified by top_read_valid.
- write_start, write_restart, top_write_valid  in  1 each  decoded write-channel strobes.
- top_write_len  in  TOP_LEN_WIDTH  write length, qualified by top_write_valid.
- read_beat, read_done, read_error  in  1 each  read engine event pulses.
- write_beat, write_done, write_error  in  1 each  write engine event pulses.
- reg_up  out  AXIL_DATA_WIDTH*NUM_REGISTER  packed status registers; register k occupies [(k+1)*64-1 : k*64].
- irq  out  1  level interrupt.

Behaviour:
- All state is registered. An event at cycle N is visible in reg_up at N+1. On reset, all outputs are 0, every channel is in IDLE, and all counters and sticky bits are cleared.
- The per-channel FSM is identical for read and write. Encoding: IDLE=0, LOADED=1, RUN=2, DONE=3, ERR=4.
  - IDLE/DONE + valid -> LOADED. The length is latched and the beat count is cleared.
  - LOADED + start -> RUN. The cycle counter is cleared.
  - LOADED + valid -> LOADED. The newer length replaces the old one.
  - RUN + done -> DONE. The done sticky bit is set.
  - LOADED/RUN + error -> ERR. The err sticky bit is set. If error and done arrive in the same cycle, error wins.
  - ERR exits only via restart.
  - restart from any state -> IDLE. Beat count, cycle count and latched length are cleared. restart wins over every other input in the same cycle.
  - start in IDLE, DONE or ERR is ignored.
  - valid in RUN or ERR is ignored and sets the overrun sticky bit.
- Beat counter:
  - Increments on beat only in RUN.
  - Saturates at the latched length; further beats are ignored.
  - Beats in any other state are ignored.
- Cycle counter: 32 bits, increments every cycle in RUN, saturates at 0xFFFF_FFFF, and holds its value after leaving RUN.
- Register map:
  - Reg 0 (status):
    - [0] read busy (state==RUN); [1] write busy.
    - [2] read done sticky; [3] write done sticky.
    - [4] read err sticky; [5] write err sticky.
    - [6] read overrun; [7] write overrun.
    - [63:8] zero.
  - Reg 1 (read channel): [TOP_LEN_WIDTH-1:0] beat count, [32+TOP_LEN_WIDTH-1:32] latched length, [58:56] state, other bits zero.
  - Reg 2 (write channel): same layout as reg 1.
  - Reg 3: [31:0] read cycle count, [63:32] write cycle count.
- Clear-on-read:
  - read_valid with access_addr==0 at cycle N: reg_up at N shows the pre-clear value, and sticky bits [7:2] are zero from N+1.
  - A sticky bit that is set by an event in the same cycle N stays 1 (set wins over clear).
  - Reads of any other register have no side effects.
- irq = OR of reg0[7:2], registered. It deasserts the cycle after a clearing read unless a new event is setting a sticky bit in that same cycle.
- Reset asserted mid-transfer returns everything to its reset values immediately (asynchronous reset). No events are recorded until rst_n deasserts.

Decomposition:
- Package top_encoder_pkg holds:
  - the state enum (3 bits, values as above);
  - status bit position constants for reg 0;
  - field offset constants (LEN_OFFSET=32, STATE_OFFSET=56).
- Sub-module top_encoder_chan (FSM, beat counter, cycle counter, sticky done/err/overrun) is instantiated twice, once per channel. The top level handles packing, clear-on-read and irq.

Test Plan:
- Nominal transfer: top_read_valid with len=4, then read_start, 4 read_beat pulses, then read_done.
  - reg1 beat count 1..4, state walks 1 -> 2 -> 3.
  - reg0[2]=1 and irq=1 one cycle after done.
  - Reg3 read cycle count equals the number of RUN cycles.
- Beat saturation and ignored beats: len=2, 5 beats in RUN -> beat count holds at 2. 3 beats in IDLE -> count stays 0.
- Error and precedence:
  - write_done and write_error in the same RUN cycle -> state=4, reg0[5]=1, reg0[3]=0.
  - write_start in ERR -> ignored.
  - write_restart -> state=0, reg2 cleared.
- Clear-on-read race: read_valid with access_addr=0 in the same cycle as read_done.
  - The read returns bit2=0.
  - Next cycle bit2=1 and irq stays 1.
  - A second read clears it; irq drops at the following cycle.
- Overrun: top_read_valid in RUN -> reg0[6]=1 and the latched length is unchanged.
- Reset mid-RUN: assert rst_n=0 asynchronously between clock edges -> reg_up=0 and irq=0 immediately. After release, all channels are IDLE.

Source files
------------

// File: rtl/top_encoder_pkg.sv
// Shared types and register-map constants for the DMA status encoder.
// Imported by the channel tracker and the register packer.
package top_encoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOADED = 3'd1,
        ST_RUN    = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } chan_state_e;

    localparam int STATE_W = 3;

    // Reg 0 status bit positions
    localparam int BIT_RD_BUSY = 0;
    localparam int BIT_WR_BUSY = 1;
    localparam int BIT_RD_DONE = 2;
    localparam int BIT_WR_DONE = 3;
    localparam int BIT_RD_ERR  = 4;
    localparam int BIT_WR_ERR  = 5;
    localparam int BIT_RD_OVR  = 6;
    localparam int BIT_WR_OVR  = 7;

    localparam int LEN_OFFSET   = 32;
    localparam int STATE_OFFSET = 56;

endpackage

// File: rtl/top_encoder_chan.sv
// One DMA channel tracker: lifecycle FSM, saturating beat and cycle counters,
// and the done/err/overrun sticky bits with clear-on-read support.
module top_encoder_chan
    import top_encoder_pkg::*;
#(
    parameter int LEN_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [LEN_W-1:0] len,
    input  logic             start,
    input  logic             restart,
    input  logic             beat,
    input  logic             done,
    input  logic             error,
    input  logic             clr,
    output logic [2:0]       state,
    output logic             busy,
    output logic [LEN_W-1:0] beat_cnt,
    output logic [LEN_W-1:0] len_q,
    output logic [31:0]      cyc_cnt,
    output logic             done_stk,
    output logic             err_stk,
    output logic             ovr_stk
);

    chan_state_e state_q, state_nxt;
    logic load_len, clr_all, clr_cyc, set_done, set_err, set_ovr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_nxt;
    end

    // restart dominates; error beats done and start within a state
    always_comb begin
        state_nxt = state_q;
        load_len  = 1'b0;
        clr_all   = 1'b0;
        clr_cyc   = 1'b0;
        set_done  = 1'b0;
        set_err   = 1'b0;
        set_ovr   = 1'b0;
        if (restart) begin
            state_nxt = ST_IDLE;
            clr_all   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (valid) begin
                        state_nxt = ST_LOADED;
                        load_len  = 1'b1;
                    end
                end
                ST_LOADED: begin
                    if (error) begin
                        state_nxt = ST_ERR;
                        set_err   = 1'b1;
                    end else if (start) begin
                        state_nxt = ST_RUN;
                        clr_cyc   = 1'b1;
                    end else if (valid) begin
                        load_len  = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (error) begin
                        state_nxt = ST_ERR;
                        set_err   = 1'b1;
                    end else if (done) begin
                        state_nxt = ST_DONE;
                        set_done  = 1'b1;
                    end
                    set_ovr = valid;
                end
                ST_ERR: set_ovr = valid;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            beat_cnt <= '0;
            cyc_cnt  <= '0;
            done_stk <= 1'b0;
            err_stk  <= 1'b0;
            ovr_stk  <= 1'b0;
        end else begin
            if (clr_all) begin
                len_q    <= '0;
                beat_cnt <= '0;
                cyc_cnt  <= '0;
            end else begin
                if (load_len) begin
                    len_q    <= len;
                    beat_cnt <= '0;
                end else if (state_q == ST_RUN && beat && beat_cnt < len_q) begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
                if (clr_cyc)
                    cyc_cnt <= '0;
                else if (state_q == ST_RUN && cyc_cnt != '1)
                    cyc_cnt <= cyc_cnt + 32'd1;
            end
            // a set in the clearing cycle survives the clear
            done_stk <= set_done | (done_stk & ~clr);
            err_stk  <= set_err  | (err_stk  & ~clr);
            ovr_stk  <= set_ovr  | (ovr_stk  & ~clr);
        end
    end

    assign state = state_q;
    assign busy  = (state_q == ST_RUN);

endmodule

// File: rtl/top_encoder.sv
// DMA status encoder: tracks read and write channels and packs their state into
// the AXI-Lite readable register bank, with clear-on-read sticky bits and irq.
module top_encoder
    import top_encoder_pkg::*;
#(
    parameter int AXIL_DATA_WIDTH = 64,
    parameter int NUM_REGISTER    = 4,
    parameter int TOP_LEN_WIDTH   = 20
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  read_valid,
    input  logic [$clog2(NUM_REGISTER)-1:0]       access_addr,
    input  logic                                  read_start,
    input  logic                                  read_restart,
    input  logic                                  top_read_valid,
    input  logic [TOP_LEN_WIDTH-1:0]              top_read_len,
    input  logic                                  write_start,
    input  logic                                  write_restart,
    input  logic                                  top_write_valid,
    input  logic [TOP_LEN_WIDTH-1:0]              top_write_len,
    input  logic                                  read_beat,
    input  logic                                  read_done,
    input  logic                                  read_error,
    input  logic                                  write_beat,
    input  logic                                  write_done,
    input  logic                                  write_error,
    output logic [AXIL_DATA_WIDTH*NUM_REGISTER-1:0] reg_up,
    output logic                                  irq
);

    localparam int W = AXIL_DATA_WIDTH;

    logic                     clr;
    logic [2:0]               rd_state, wr_state;
    logic                     rd_busy, wr_busy;
    logic [TOP_LEN_WIDTH-1:0] rd_beat, wr_beat, rd_len, wr_len;
    logic [31:0]              rd_cyc, wr_cyc;
    logic                     rd_done_s, wr_done_s, rd_err_s, wr_err_s, rd_ovr_s, wr_ovr_s;

    assign clr = read_valid && (access_addr == '0);

    top_encoder_chan #(.LEN_W(TOP_LEN_WIDTH)) u_rd (
        .clk(clk), .rst_n(rst_n),
        .valid(top_read_valid), .len(top_read_len),
        .start(read_start), .restart(read_restart),
        .beat(read_beat), .done(read_done), .error(read_error), .clr(clr),
        .state(rd_state), .busy(rd_busy), .beat_cnt(rd_beat), .len_q(rd_len),
        .cyc_cnt(rd_cyc), .done_stk(rd_done_s), .err_stk(rd_err_s), .ovr_stk(rd_ovr_s)
    );

    top_encoder_chan #(.LEN_W(TOP_LEN_WIDTH)) u_wr (
        .clk(clk), .rst_n(rst_n),
        .valid(top_write_valid), .len(top_write_len),
        .start(write_start), .restart(write_restart),
        .beat(write_beat), .done(write_done), .error(write_error), .clr(clr),
        .state(wr_state), .busy(wr_busy), .beat_cnt(wr_beat), .len_q(wr_len),
        .cyc_cnt(wr_cyc), .done_stk(wr_done_s), .err_stk(wr_err_s), .ovr_stk(wr_ovr_s)
    );

    // Every field is a direct view of channel flops, so async reset zeroes reg_up at once
    always_comb begin
        reg_up = '0;
        reg_up[BIT_RD_BUSY] = rd_busy;
        reg_up[BIT_WR_BUSY] = wr_busy;
        reg_up[BIT_RD_DONE] = rd_done_s;
        reg_up[BIT_WR_DONE] = wr_done_s;
        reg_up[BIT_RD_ERR]  = rd_err_s;
        reg_up[BIT_WR_ERR]  = wr_err_s;
        reg_up[BIT_RD_OVR]  = rd_ovr_s;
        reg_up[BIT_WR_OVR]  = wr_ovr_s;
        reg_up[W   +: TOP_LEN_WIDTH]                = rd_beat;
        reg_up[W   + LEN_OFFSET +: TOP_LEN_WIDTH]   = rd_len;
        reg_up[W   + STATE_OFFSET +: STATE_W]       = rd_state;
        reg_up[2*W +: TOP_LEN_WIDTH]                = wr_beat;
        reg_up[2*W + LEN_OFFSET +: TOP_LEN_WIDTH]   = wr_len;
        reg_up[2*W + STATE_OFFSET +: STATE_W]       = wr_state;
        reg_up[3*W +: 32]                           = rd_cyc;
        reg_up[3*W + 32 +: 32]                      = wr_cyc;
    end

    assign irq = rd_done_s | wr_done_s | rd_err_s | wr_err_s | rd_ovr_s | wr_ovr_s;

endmodule

// File: tb/tb_top_encoder.sv
// Directed bench for top_encoder: nominal transfer, saturation, error precedence,
// clear-on-read race, overrun and asynchronous reset.
module tb_top_encoder;

    localparam int NR = 4;
    localparam int LW = 20;

    logic          clk;
    logic          rst_n;
    logic          read_valid;
    logic [1:0]    access_addr;
    logic          read_start, read_restart, top_read_valid;
    logic [LW-1:0] top_read_len;
    logic          write_start, write_restart, top_write_valid;
    logic [LW-1:0] top_write_len;
    logic          read_beat, read_done, read_error;
    logic          write_beat, write_done, write_error;
    logic [64*NR-1:0] reg_up;
    logic          irq;

    int checks   = 0;
    int failures = 0;

    top_encoder #(.AXIL_DATA_WIDTH(64), .NUM_REGISTER(NR), .TOP_LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .read_valid(read_valid), .access_addr(access_addr),
        .read_start(read_start), .read_restart(read_restart),
        .top_read_valid(top_read_valid), .top_read_len(top_read_len),
        .write_start(write_start), .write_restart(write_restart),
        .top_write_valid(top_write_valid), .top_write_len(top_write_len),
        .read_beat(read_beat), .read_done(read_done), .read_error(read_error),
        .write_beat(write_beat), .write_done(write_done), .write_error(write_error),
        .reg_up(reg_up), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rg(input int k);
        return reg_up[k*64 +: 64];
    endfunction

    function automatic logic [2:0] st(input int k);
        logic [63:0] r;
        r = reg_up[k*64 +: 64];
        return r[58:56];
    endfunction

    function automatic logic [LW-1:0] bc(input int k);
        logic [63:0] r;
        r = reg_up[k*64 +: 64];
        return r[LW-1:0];
    endfunction

    function automatic logic [LW-1:0] ln(input int k);
        logic [63:0] r;
        r = reg_up[k*64 +: 64];
        return r[32 +: LW];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reg0();
        read_valid = 1'b1; access_addr = 2'd0;
        step();
        read_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        {read_valid, read_start, read_restart, top_read_valid} = '0;
        {write_start, write_restart, top_write_valid} = '0;
        {read_beat, read_done, read_error, write_beat, write_done, write_error} = '0;
        access_addr = '0; top_read_len = '0; top_write_len = '0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (reg_up !== '0) begin failures++; $display("FAIL reset_reg_up actual=%h required=0", reg_up); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq actual=%b required=0", irq); end
        step(); step();
        @(negedge clk) rst_n = 1'b1;
        step();
        checks++;
        if (reg_up !== '0) begin failures++; $display("FAIL reset_release actual=%h required=0", reg_up); end
    endtask

    task automatic test_nominal();
        top_read_valid = 1'b1; top_read_len = 20'd4;
        step();
        top_read_valid = 1'b0;
        checks++;
        if (st(1) !== 3'd1 || ln(1) !== 20'd4 || bc(1) !== '0) begin
            failures++; $display("FAIL nominal_load actual=state %0d len %0d beat %0d required=1 4 0", st(1), ln(1), bc(1));
        end
        read_start = 1'b1;
        step();
        read_start = 1'b0;
        checks++;
        if (st(1) !== 3'd2 || rg(0) !== 64'h1) begin
            failures++; $display("FAIL nominal_run actual=state %0d reg0 %h required=2 1", st(1), rg(0));
        end
        for (int i = 1; i <= 4; i++) begin
            read_beat = 1'b1;
            step();
            checks++;
            if (bc(1) !== LW'(i)) begin failures++; $display("FAIL nominal_beat actual=%0d required=%0d", bc(1), i); end
        end
        read_beat = 1'b0;
        read_done = 1'b1;
        step();
        read_done = 1'b0;
        checks++;
        if (st(1) !== 3'd3 || rg(0) !== 64'h4 || irq !== 1'b1) begin
            failures++; $display("FAIL nominal_done actual=state %0d reg0 %h irq %b required=3 4 1", st(1), rg(0), irq);
        end
        // 4 beat cycles plus the done cycle were spent in RUN
        checks++;
        if (rg(3) !== 64'd5) begin failures++; $display("FAIL nominal_cycles actual=%h required=5", rg(3)); end
        read_valid = 1'b1; access_addr = 2'd0;
        checks++;
        if (rg(0) !== 64'h4) begin failures++; $display("FAIL nominal_preclear actual=%h required=4", rg(0)); end
        step();
        read_valid = 1'b0;
        checks++;
        if (rg(0) !== '0 || irq !== 1'b0) begin
            failures++; $display("FAIL nominal_clear actual=reg0 %h irq %b required=0 0", rg(0), irq);
        end
        step();
        checks++;
        if (rg(3) !== 64'd5) begin failures++; $display("FAIL nominal_cyc_hold actual=%h required=5", rg(3)); end
    endtask

    task automatic test_saturation();
        top_read_valid = 1'b1; top_read_len = 20'd2;
        step();
        top_read_valid = 1'b0;
        read_start = 1'b1;
        step();
        read_start = 1'b0;
        read_beat = 1'b1;
        for (int i = 0; i < 5; i++) step();
        read_beat = 1'b0;
        checks++;
        if (bc(1) !== 20'd2 || st(1) !== 3'd2) begin
            failures++; $display("FAIL sat_beats actual=beat %0d state %0d required=2 2", bc(1), st(1));
        end
        read_restart = 1'b1;
        step();
        read_restart = 1'b0;
        checks++;
        if (rg(1) !== '0 || rg(3) !== '0) begin
            failures++; $display("FAIL sat_restart actual=reg1 %h reg3 %h required=0 0", rg(1), rg(3));
        end
        read_beat = 1'b1;
        for (int i = 0; i < 3; i++) step();
        read_beat = 1'b0;
        checks++;
        if (rg(1) !== '0) begin failures++; $display("FAIL sat_idle_beats actual=%h required=0", rg(1)); end
    endtask

    task automatic test_error();
        top_write_valid = 1'b1; top_write_len = 20'd3;
        step();
        top_write_valid = 1'b0;
        write_start = 1'b1;
        step();
        write_start = 1'b0;
        write_done = 1'b1; write_error = 1'b1;
        step();
        write_done = 1'b0; write_error = 1'b0;
        checks++;
        if (st(2) !== 3'd4 || rg(0) !== 64'h20 || irq !== 1'b1) begin
            failures++; $display("FAIL err_precedence actual=state %0d reg0 %h irq %b required=4 20 1", st(2), rg(0), irq);
        end
        write_start = 1'b1;
        step();
        write_start = 1'b0;
        checks++;
        if (st(2) !== 3'd4) begin failures++; $display("FAIL err_start_ignored actual=%0d required=4", st(2)); end
        write_restart = 1'b1;
        step();
        write_restart = 1'b0;
        checks++;
        if (rg(2) !== '0) begin failures++; $display("FAIL err_restart actual=%h required=0", rg(2)); end
        clear_reg0();
        checks++;
        if (rg(0) !== '0 || irq !== 1'b0) begin
            failures++; $display("FAIL err_clear actual=reg0 %h irq %b required=0 0", rg(0), irq);
        end
    endtask

    task automatic test_clr_race();
        top_read_valid = 1'b1; top_read_len = 20'd1;
        step();
        top_read_valid = 1'b0;
        read_start = 1'b1;
        step();
        read_start = 1'b0;
        read_done = 1'b1; read_valid = 1'b1; access_addr = 2'd0;
        checks++;
        if (rg(0) !== 64'h1) begin failures++; $display("FAIL race_read_value actual=%h required=1", rg(0)); end
        step();
        read_done = 1'b0; read_valid = 1'b0;
        checks++;
        if (rg(0) !== 64'h4 || irq !== 1'b1) begin
            failures++; $display("FAIL race_set_wins actual=reg0 %h irq %b required=4 1", rg(0), irq);
        end
        read_valid = 1'b1; access_addr = 2'd1;
        step();
        read_valid = 1'b0;
        checks++;
        if (rg(0) !== 64'h4) begin failures++; $display("FAIL race_other_addr actual=%h required=4", rg(0)); end
        clear_reg0();
        checks++;
        if (rg(0) !== '0 || irq !== 1'b0) begin
            failures++; $display("FAIL race_second_clear actual=reg0 %h irq %b required=0 0", rg(0), irq);
        end
    endtask

    task automatic test_overrun();
        top_read_valid = 1'b1; top_read_len = 20'd5;
        step();
        top_read_valid = 1'b0;
        read_start = 1'b1;
        step();
        read_start = 1'b0;
        top_read_valid = 1'b1; top_read_len = 20'd9;
        step();
        top_read_valid = 1'b0;
        checks++;
        if (rg(0) !== 64'h41 || ln(1) !== 20'd5 || st(1) !== 3'd2 || irq !== 1'b1) begin
            failures++;
            $display("FAIL overrun actual=reg0 %h len %0d state %0d irq %b required=41 5 2 1", rg(0), ln(1), st(1), irq);
        end
    endtask

    task automatic test_reset_mid();
        top_write_valid = 1'b1; top_write_len = 20'd7;
        step();
        top_write_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (reg_up !== '0 || irq !== 1'b0) begin
            failures++; $display("FAIL reset_mid actual=reg_up %h irq %b required=0 0", reg_up, irq);
        end
        read_beat = 1'b1; read_done = 1'b1;
        step(); step();
        read_beat = 1'b0; read_done = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        step();
        checks++;
        if (reg_up !== '0 || st(1) !== 3'd0 || st(2) !== 3'd0) begin
            failures++; $display("FAIL reset_mid_release actual=%h required=0", reg_up);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_saturation();
        test_error();
        test_clr_race();
        test_overrun();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
